mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, consuming the EX/MEM register bundle. It resolves branches, drives a handshaked data-memory port that may take several cycles, stalls upstream stages while an access is in flight, and owns the MEM/WB pipeline register feeding write-back. A saturating taken-branch counter is kept for performance debug.

---
 rtl/mem_stage.sv | 154 +++++++++++++++
 tb/tb_mem_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: branch resolution, handshaked data-memory port,
// upstream stall generation, MEM/WB register and a saturating taken-branch counter.
`timescale 1ns/1ps
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       M_WB,
    input  logic             M_Branch,
    input  logic             M_BNE,
    input  logic             M_BranchCon,
    input  logic             M_MemRead,
    input  logic             M_MemWrite,
    input  logic             M_ZeroFlag,
    input  logic [31:0]      M_BranchAddResult,
    input  logic [31:0]      M_PCinc,
    input  logic [31:0]      M_ALUResult,
    input  logic [31:0]      M_WriteMemData,
    input  logic [4:0]       M_WriteRegData,
    input  logic             DMemReady,
    input  logic [31:0]      DMemRData,
    output logic             DMemReq,
    output logic             DMemWe,
    output logic [31:0]      DMemAddr,
    output logic [31:0]      DMemWData,
    output logic             Stall,
    output logic             PCSrc,
    output logic [31:0]      BranchTarget,
    output logic             Flush,
    output logic [3:0]       WB_WB,
    output logic [31:0]      WB_ReadData,
    output logic [31:0]      WB_ALUResult,
    output logic [31:0]      WB_PCinc,
    output logic [4:0]       WB_WriteReg,
    output logic             MemError,
    output logic [CNT_W-1:0] BranchTakenCount
);

    localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic              mem_op;
    logic              taken;
    logic              timeout_hit;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [31:0]       rdata_q;

    assign mem_op      = M_MemRead | M_MemWrite;
    assign taken       = (M_Branch & M_ZeroFlag) | (M_BNE & ~M_ZeroFlag) | M_BranchCon;
    // wait_cnt counts completed BUSY cycles, so the last allowed one sees TIMEOUT-1
    assign timeout_hit = (wait_cnt == WCNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        DMemReq   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    Stall     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                Stall   = 1'b1;
                DMemReq = 1'b1;
                if (DMemReady || timeout_hit)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign DMemWe       = DMemReq & we_q;
    assign DMemAddr     = DMemReq ? addr_q  : 32'h0;
    assign DMemWData    = DMemReq ? wdata_q : 32'h0;
    assign PCSrc        = taken & ~Stall;
    assign Flush        = PCSrc;
    assign BranchTarget = M_BranchAddResult;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == BUSY) ? wait_cnt + WCNT_W'(1) : '0;
        end
    end

    // Request latches and read capture; a both-set op is a store and returns 0
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            MemError <= 1'b0;
        end else begin
            if (state == IDLE && mem_op) begin
                addr_q  <= M_ALUResult;
                wdata_q <= M_WriteMemData;
                we_q    <= M_MemWrite;
            end
            if (state == BUSY) begin
                if (DMemReady) begin
                    rdata_q <= we_q ? 32'h0 : DMemRData;
                end else if (timeout_hit) begin
                    rdata_q  <= 32'h0;
                    MemError <= 1'b1;
                end
            end
        end
    end

    // Stalled edges write a bubble so an instruction retires exactly once
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            WB_WB        <= '0;
            WB_ReadData  <= '0;
            WB_ALUResult <= '0;
            WB_PCinc     <= '0;
            WB_WriteReg  <= '0;
        end else if (Stall) begin
            WB_WB        <= '0;
            WB_ReadData  <= '0;
            WB_ALUResult <= '0;
            WB_PCinc     <= '0;
            WB_WriteReg  <= '0;
        end else begin
            WB_WB        <= M_WB;
            WB_ReadData  <= (state == DONE) ? rdata_q : 32'h0;
            WB_ALUResult <= M_ALUResult;
            WB_PCinc     <= M_PCinc;
            WB_WriteReg  <= M_WriteRegData;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            BranchTakenCount <= '0;
        else if (PCSrc && (BranchTakenCount != {CNT_W{1'b1}}))
            BranchTakenCount <= BranchTakenCount + CNT_W'(1);
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: expected MEM/WB contents are queued at issue
// and compared when a non-zero write-back bundle appears.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [3:0]       M_WB;
    logic             M_Branch, M_BNE, M_BranchCon, M_MemRead, M_MemWrite, M_ZeroFlag;
    logic [31:0]      M_BranchAddResult, M_PCinc, M_ALUResult, M_WriteMemData;
    logic [4:0]       M_WriteRegData;
    logic             DMemReady;
    logic [31:0]      DMemRData;
    logic             DMemReq, DMemWe, Stall, PCSrc, Flush, MemError;
    logic [31:0]      DMemAddr, DMemWData, BranchTarget;
    logic [3:0]       WB_WB;
    logic [31:0]      WB_ReadData, WB_ALUResult, WB_PCinc;
    logic [4:0]       WB_WriteReg;
    logic [CNT_W-1:0] BranchTakenCount;

    mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .M_WB(M_WB), .M_Branch(M_Branch), .M_BNE(M_BNE),
        .M_BranchCon(M_BranchCon), .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite),
        .M_ZeroFlag(M_ZeroFlag), .M_BranchAddResult(M_BranchAddResult), .M_PCinc(M_PCinc),
        .M_ALUResult(M_ALUResult), .M_WriteMemData(M_WriteMemData),
        .M_WriteRegData(M_WriteRegData), .DMemReady(DMemReady), .DMemRData(DMemRData),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
        .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Flush(Flush),
        .WB_WB(WB_WB), .WB_ReadData(WB_ReadData), .WB_ALUResult(WB_ALUResult),
        .WB_PCinc(WB_PCinc), .WB_WriteReg(WB_WriteReg), .MemError(MemError),
        .BranchTakenCount(BranchTakenCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  wreg;
    } wb_t;

    wb_t         sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          zero_wb  = 0;

    // memory model state
    logic [31:0] mem [logic [31:0]];
    int          mem_lat  = 0;
    bit          mem_dead = 0;
    int          busy_cnt = 0;
    int          req_starts = 0;
    bit          req_prev = 0;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;

    // Write-back monitor / scoreboard
    always @(negedge Clk) begin
        wb_t act, exp_e;
        act = {WB_WB, WB_ReadData, WB_ALUResult, WB_PCinc, WB_WriteReg};
        if (Reset === 1'b1) begin
            if (act.wb != 4'h0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_unexpected: got %h, required no write-back", act);
                end else begin
                    exp_e = sb.pop_front();
                    if (act !== exp_e) begin
                        n_fail++;
                        $display("FAIL wb_bundle: got %h, required %h", act, exp_e);
                    end
                end
            end else if (act == '0) begin
                zero_wb++;
            end
        end
    end

    // Data-memory responder: completes after mem_lat extra BUSY cycles
    initial begin
        DMemReady = 1'b0;
        DMemRData = 32'h0;
        forever begin
            @(negedge Clk);
            if (DMemReq === 1'b1 && Reset === 1'b1) begin
                if (!req_prev) req_starts++;
                if (!mem_dead && busy_cnt == mem_lat) begin
                    DMemReady  = 1'b1;
                    DMemRData  = mem.exists(DMemAddr) ? mem[DMemAddr] : 32'h0;
                    last_we    = DMemWe;
                    last_addr  = DMemAddr;
                    last_wdata = DMemWData;
                    if (DMemWe) mem[DMemAddr] = DMemWData;
                end else begin
                    DMemReady = 1'b0;
                    DMemRData = 32'hBAD0_0000 | busy_cnt;
                end
                busy_cnt++;
            end else begin
                DMemReady = 1'b0;
                DMemRData = 32'hBAD1_1111;
                busy_cnt  = 0;
            end
            req_prev = (DMemReq === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nop();
        M_WB = 4'h0; M_Branch = 1'b0; M_BNE = 1'b0; M_BranchCon = 1'b0;
        M_MemRead = 1'b0; M_MemWrite = 1'b0; M_ZeroFlag = 1'b0;
        M_BranchAddResult = 32'h0; M_PCinc = 32'h0; M_ALUResult = 32'h0;
        M_WriteMemData = 32'h0; M_WriteRegData = 5'd0;
    endtask

    // Present one instruction, hold it while stalled, return the stall-cycle count
    task automatic issue(input logic [3:0] wb, input logic rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] wdata, input logic [4:0] wreg,
                         input logic [31:0] exp_rd, output int nstall);
        @(negedge Clk);
        nop();
        M_WB = wb; M_MemRead = rd; M_MemWrite = wr; M_ALUResult = alu;
        M_PCinc = pc; M_WriteMemData = wdata; M_WriteRegData = wreg;
        if (wb != 4'h0) sb.push_back({wb, exp_rd, alu, pc, wreg});
        nstall = 0;
        #1;
        while (Stall && nstall < 50) begin
            nstall++;
            @(negedge Clk);
            #1;
        end
        @(posedge Clk);
        #1;
        nop();
    endtask

    task automatic drain(input string tag);
        repeat (2) @(negedge Clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending write-backs, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        nop();
        repeat (3) @(negedge Clk);
        #1;
        n_checks++;
        if ({WB_WB, WB_ReadData, WB_ALUResult, WB_PCinc, WB_WriteReg} !== 105'h0) begin
            n_fail++; $display("FAIL reset_wb: got %h %h, required zero", WB_WB, WB_ALUResult);
        end
        n_checks++;
        if ({DMemReq, DMemWe, DMemAddr, DMemWData, Stall, PCSrc, Flush} !== 69'h0) begin
            n_fail++; $display("FAIL reset_outs: got req=%b we=%b addr=%h stall=%b, required 0", DMemReq, DMemWe, DMemAddr, Stall);
        end
        n_checks++;
        if (MemError !== 1'b0 || BranchTakenCount !== '0) begin
            n_fail++; $display("FAIL reset_err_cnt: got %b %0d, required 0 0", MemError, BranchTakenCount);
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_nonmem();
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(4'h9 + 4'(i), 1'b0, 1'b0, 32'h1234_5600 + 32'(i), 32'h0040_0004 + 32'(4*i),
                  32'hFFFF_0000, 5'd3 + 5'(i), 32'h0, n);
            n_checks++;
            if (n != 0) begin
                n_fail++; $display("FAIL nonmem_stall: got %0d, required 0", n);
            end
        end
        drain("nonmem");
    endtask

    task automatic test_load();
        int n, z0;
        mem_lat = 2;
        issue(4'hA, 1'b0, 1'b0, 32'h0000_0777, 32'h0040_0100, 32'h0, 5'd2, 32'h0, n);
        z0 = zero_wb;
        issue(4'h5, 1'b1, 1'b0, 32'h0000_0100, 32'h0040_0104, 32'h0, 5'd7, 32'hDEAD_BEEF, n);
        n_checks++;
        if (n != 4) begin
            n_fail++; $display("FAIL load_stall: got %0d, required 4", n);
        end
        n_checks++;
        if (zero_wb - z0 != 4) begin
            n_fail++; $display("FAIL load_bubbles: got %0d, required 4", zero_wb - z0);
        end
        n_checks++;
        if (last_we !== 1'b0 || last_addr !== 32'h100) begin
            n_fail++; $display("FAIL load_req: got we=%b addr=%h, required 0 00000100", last_we, last_addr);
        end
        mem_lat = 0;
        drain("load");
    endtask

    task automatic test_back_to_back();
        int n, r0;
        mem_lat = 0;
        r0 = req_starts;
        issue(4'h2, 1'b0, 1'b1, 32'h0000_0040, 32'h0040_0200, 32'h0000_0055, 5'd0, 32'h0, n);
        n_checks++;
        if (n != 2 || last_we !== 1'b1 || last_addr !== 32'h40 || last_wdata !== 32'h55) begin
            n_fail++; $display("FAIL store_req: got n=%0d we=%b addr=%h data=%h, required 2 1 00000040 00000055", n, last_we, last_addr, last_wdata);
        end
        issue(4'h5, 1'b1, 1'b0, 32'h0000_0040, 32'h0040_0204, 32'h0, 5'd9, 32'h0000_0055, n);
        n_checks++;
        if (n != 2 || last_we !== 1'b0) begin
            n_fail++; $display("FAIL reload_req: got n=%0d we=%b, required 2 0", n, last_we);
        end
        n_checks++;
        if (req_starts - r0 != 2) begin
            n_fail++; $display("FAIL b2b_req_periods: got %0d, required 2", req_starts - r0);
        end
        drain("b2b");
    endtask

    task automatic test_branches();
        logic [4:0] tbl [3];   // {Branch, BNE, BranchCon, Zero, expected taken}
        tbl[0] = 5'b1001_1;
        tbl[1] = 5'b0101_0;
        tbl[2] = 5'b0010_1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            nop();
            {M_Branch, M_BNE, M_BranchCon, M_ZeroFlag} = tbl[i][4:1];
            M_BranchAddResult = 32'h0000_1000 + 32'(16*i);
            #1;
            n_checks++;
            if (PCSrc !== tbl[i][0] || Flush !== tbl[i][0]) begin
                n_fail++; $display("FAIL branch_%0d_pcsrc: got %b/%b, required %b", i, PCSrc, Flush, tbl[i][0]);
            end
            n_checks++;
            if (BranchTarget !== 32'h0000_1000 + 32'(16*i)) begin
                n_fail++; $display("FAIL branch_%0d_target: got %h, required %h", i, BranchTarget, 32'h0000_1000 + 32'(16*i));
            end
            @(posedge Clk);
            #1;
            nop();
        end
        n_checks++;
        if (BranchTakenCount !== 2'd2) begin
            n_fail++; $display("FAIL branch_count: got %0d, required 2", BranchTakenCount);
        end
    endtask

    task automatic test_timeout();
        int n;
        n_checks++;
        if (MemError !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pre_err: got %b, required 0", MemError);
        end
        mem_dead = 1;
        issue(4'hC, 1'b1, 1'b0, 32'h0000_0200, 32'h0040_0300, 32'h0, 5'd12, 32'h0, n);
        mem_dead = 0;
        n_checks++;
        if (n != 1 + TIMEOUT) begin
            n_fail++; $display("FAIL timeout_stall: got %0d, required %0d", n, 1 + TIMEOUT);
        end
        n_checks++;
        if (MemError !== 1'b1) begin
            n_fail++; $display("FAIL timeout_err: got %b, required 1", MemError);
        end
        issue(4'h3, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0040_0304, 32'h0, 5'd13, 32'h0, n);
        n_checks++;
        if (n != 0 || MemError !== 1'b1) begin
            n_fail++; $display("FAIL timeout_resume: got n=%0d err=%b, required 0 1", n, MemError);
        end
        drain("timeout");
    endtask

    task automatic test_reset_mid_busy();
        int n;
        mem_dead = 1;
        @(negedge Clk);
        nop();
        M_WB = 4'h6; M_MemRead = 1'b1; M_ALUResult = 32'h0000_0300; M_WriteRegData = 5'd4;
        repeat (2) @(negedge Clk);
        #1;
        n_checks++;
        if (DMemReq !== 1'b1) begin
            n_fail++; $display("FAIL rst_busy_pre: got req=%b, required 1", DMemReq);
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if (DMemReq !== 1'b0 || DMemAddr !== 32'h0) begin
            n_fail++; $display("FAIL rst_busy_req: got req=%b addr=%h, required 0", DMemReq, DMemAddr);
        end
        n_checks++;
        if (MemError !== 1'b0 || BranchTakenCount !== '0 ||
            {WB_WB, WB_ReadData, WB_ALUResult, WB_PCinc, WB_WriteReg} !== 105'h0) begin
            n_fail++; $display("FAIL rst_busy_state: got err=%b cnt=%0d wb=%h, required zeros", MemError, BranchTakenCount, WB_WB);
        end
        nop();
        #1;
        n_checks++;
        if (Stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy_idle: got stall=%b, required 0", Stall);
        end
        @(negedge Clk);
        Reset = 1'b1;
        mem_dead = 0;
        issue(4'h7, 1'b0, 1'b0, 32'h0000_0D00, 32'h0040_0400, 32'h0, 5'd5, 32'h0, n);
        n_checks++;
        if (n != 0) begin
            n_fail++; $display("FAIL rst_busy_release: got %0d stalls, required 0", n);
        end
        drain("rst_busy");
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            nop();
            M_BranchCon = 1'b1;
            M_BranchAddResult = 32'h0000_2000 + 32'(i);
            @(posedge Clk);
            #1;
            nop();
            n_checks++;
            if (BranchTakenCount !== CNT_W'((i > 3) ? 3 : i)) begin
                n_fail++; $display("FAIL sat_count_%0d: got %0d, required %0d", i, BranchTakenCount, (i > 3) ? 3 : i);
            end
        end
    endtask

    initial begin
        mem[32'h0000_0100] = 32'hDEAD_BEEF;
        test_reset();
        test_nonmem();
        test_load();
        test_back_to_back();
        test_branches();
        test_timeout();
        test_reset_mid_busy();
        test_saturation();
        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
